// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
package prio_enc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;

  // Priority mode, carried per word through the pipe.
  localparam logic PRIO_LSB = 1'b0;
  localparam logic PRIO_MSB = 1'b1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prio_group_enc.sv
// Combinational N-bit priority encoder.
// It reports whether any bit is set, the index of the winning bit for the chosen
// priority mode, and whether two or more bits are set.
module prio_group_enc
  import prio_enc_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  bits,
  input  logic          mode,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic          multi
);

  // Scan from bit 0 upward.
  // In LSB mode the first hit wins. In MSB mode the last hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that left one unassigned would infer a latch.
    any   = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (bits[i]) begin
        // NOTE: blocking '=' is intended here, so later iterations see the running any/multi values.
        if (mode == PRIO_MSB || !any) idx = IW'(i);
        multi = multi | any;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Two-stage pipelined priority encoder with valid/ready on both sides.
// Stage 1 encodes each GROUP-bit slice.
// Stage 2 picks the winning group and forms the final index and flags.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP,
  parameter int IDX_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi
);

  localparam int NG    = WIDTH / GROUP;
  localparam int LOG_G = clog2(GROUP);
  localparam int LW    = (GROUP > 1) ? LOG_G : 1;
  localparam int GW    = (NG > 1) ? clog2(NG) : 1;

  if (WIDTH < 4 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0 ||
      GROUP < 1 || (GROUP & (GROUP - 1)) != 0 || GROUP > WIDTH) begin : g_bad_params
    $error("prio_encoder_pipe: WIDTH must be a power of 2 in 4..256 and GROUP a power of 2 dividing it");
  end

  // Handshake. enable gates every advance, so enable=0 freezes the whole pipe.
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv    = enable & (~s2_valid | out_ready);
  assign s1_adv    = enable & (~s1_valid | s2_adv);
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1 (combinational): one encoder per group.
  logic [NG-1:0]         grp_any, grp_multi;
  logic [NG-1:0][LW-1:0] grp_idx;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    prio_group_enc #(.N(GROUP)) u_enc (
      .bits  (in_data[g*GROUP +: GROUP]),
      .mode  (in_msb_first),
      .any   (grp_any[g]),
      .idx   (grp_idx[g]),
      .multi (grp_multi[g])
    );
  end

  // Stage 1 register. The mode bit travels with its word.
  logic [NG-1:0]         s1_any, s1_multi;
  logic [NG-1:0][LW-1:0] s1_idx;
  logic                  s1_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are cleared along with the valids, so nothing from before the reset is visible afterwards.
      s1_valid <= 1'b0;
      s1_any   <= '0;
      s1_multi <= '0;
      s1_idx   <= '0;
      s1_mode  <= PRIO_LSB;
    end else if (s1_adv) begin
      // NOTE: non-blocking '<=' on all state, so each register samples the values from before the edge.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_any   <= grp_any;
        s1_multi <= grp_multi;
        s1_idx   <= grp_idx;
        s1_mode  <= in_msb_first;
      end
    end
  end

  // Stage 2 (combinational): the same encoder, applied to the group-any vector.
  logic          sel_any, sel_multi;
  logic [GW-1:0] sel_grp;
  logic [IDX_W-1:0] idx_next;

  prio_group_enc #(.N(NG)) u_sel (
    .bits  (s1_any),
    .mode  (s1_mode),
    .any   (sel_any),
    .idx   (sel_grp),
    .multi (sel_multi)
  );

  // GROUP is a power of 2, so g*GROUP + local is a shift-and-OR.
  // An all-zero word yields sel_grp=0 and local=0, so the index is 0.
  always_comb begin
    idx_next = (IDX_W'(sel_grp) << LOG_G) | IDX_W'(s1_idx[sel_grp]);
  end

  // Stage 2 register: holds the registered outputs while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_idx   <= idx_next;
        out_zero  <= ~sel_any;
        out_multi <= (|s1_multi) | sel_multi;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Self-checking bench for prio_encoder_pipe.
// Two instances share all control signals: WIDTH=16/GROUP=4 and WIDTH=32/GROUP=8.
// Expected results are queued on accept and compared on output handshake.
module tb_prio_encoder_pipe;

  localparam int W0 = 16;
  localparam int G0 = 4;
  localparam int W1 = 32;
  localparam int G1 = 8;

  logic          clk = 1'b0;
  logic          reset, enable, in_valid, out_ready, msb;
  logic [W0-1:0] d0;
  logic [W1-1:0] d1;
  logic          ir0, ir1, ov0, ov1, z0, z1, m0, m1;
  logic [3:0]    idx0;
  logic [4:0]    idx1;

  always #5 clk = ~clk;

  prio_encoder_pipe #(.WIDTH(W0), .GROUP(G0)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(ir0),
    .in_data(d0), .in_msb_first(msb), .out_valid(ov0), .out_ready(out_ready),
    .out_idx(idx0), .out_zero(z0), .out_multi(m0)
  );

  prio_encoder_pipe #(.WIDTH(W1), .GROUP(G1)) dut32 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(ir1),
    .in_data(d1), .in_msb_first(msb), .out_valid(ov1), .out_ready(out_ready),
    .out_idx(idx1), .out_zero(z1), .out_multi(m1)
  );

  typedef struct {
    logic [31:0] idx;
    logic        zero;
    logic        multi;
  } res_t;

  typedef struct {
    logic [15:0] data;
    logic        msb;
    logic [31:0] idx;
    logic        zero;
    logic        multi;
  } vec_t;

  res_t q0[$];
  res_t q1[$];
  res_t tab_exp;
  logic use_tab = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: counts set bits and scans in the requested direction.
  function automatic res_t model(input logic [31:0] d, input int w, input logic m);
    res_t r;
    int   n;
    r.idx = 32'd0;
    n     = 0;
    for (int i = 0; i < w; i++) if (d[i]) n++;
    if (m) begin
      for (int i = 0; i < w; i++) if (d[i]) r.idx = 32'(i);
    end else begin
      for (int i = w - 1; i >= 0; i--) if (d[i]) r.idx = 32'(i);
    end
    r.zero  = (n == 0);
    r.multi = (n > 1);
    return r;
  endfunction

  // Scoreboard monitor. It samples on the falling edge, so the handshakes seen here
  // complete on the next rising edge.
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (enable && out_ready && ov0) begin
        if (q0.size() == 0) check("w16 output with empty scoreboard", 32'(q0.size()), 32'd1);
        else begin
          e = q0.pop_front();
          check("w16 idx", 32'(idx0), e.idx);
          check("w16 zero", 32'(z0), 32'(e.zero));
          check("w16 multi", 32'(m0), 32'(e.multi));
        end
      end
      if (enable && out_ready && ov1) begin
        if (q1.size() == 0) check("w32 output with empty scoreboard", 32'(q1.size()), 32'd1);
        else begin
          e = q1.pop_front();
          check("w32 idx", 32'(idx1), e.idx);
          check("w32 zero", 32'(z1), 32'(e.zero));
          check("w32 multi", 32'(m1), 32'(e.multi));
        end
      end
      if (in_valid && ir0) begin
        if (use_tab) q0.push_back(tab_exp);
        else         q0.push_back(model({16'h0, d0}, W0, msb));
      end
      if (in_valid && ir1) q1.push_back(model(d1, W1, msb));
    end
  end

  // Offer one word until both instances accept it. Call and return just after a rising edge.
  task automatic send(input logic [15:0] v0, input logic [31:0] v1, input logic mm,
                      input res_t e, input logic tab);
    int n;
    n        = 0;
    d0       = v0;
    d1       = v1;
    msb      = mm;
    tab_exp  = e;
    use_tab  = tab;
    in_valid = 1'b1;
    @(negedge clk);
    while (!(ir0 && ir1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(ir0 && ir1)) check("accept timeout", 32'(ir0 & ir1), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain scoreboard empty", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    res_t none;
    res_t e0, e1;
    none = '{idx: 32'd0, zero: 1'b0, multi: 1'b0};

    // Vector table. Expected values are written out by hand.
    for (int k = 0; k < 16; k++)
      tab.push_back('{data: 16'(1 << k), msb: 1'b0, idx: 32'(k), zero: 1'b0, multi: 1'b0});
    tab.push_back('{data: 16'h8421, msb: 1'b0, idx: 32'd0,  zero: 1'b0, multi: 1'b1});
    tab.push_back('{data: 16'h8421, msb: 1'b1, idx: 32'd15, zero: 1'b0, multi: 1'b1});
    tab.push_back('{data: 16'h0000, msb: 1'b0, idx: 32'd0,  zero: 1'b1, multi: 1'b0});
    tab.push_back('{data: 16'h0000, msb: 1'b1, idx: 32'd0,  zero: 1'b1, multi: 1'b0});
    tab.push_back('{data: 16'h00F0, msb: 1'b1, idx: 32'd7,  zero: 1'b0, multi: 1'b1});
    tab.push_back('{data: 16'h0180, msb: 1'b0, idx: 32'd7,  zero: 1'b0, multi: 1'b1});
    tab.push_back('{data: 16'h0180, msb: 1'b1, idx: 32'd8,  zero: 1'b0, multi: 1'b1});
    tab.push_back('{data: 16'h0001, msb: 1'b1, idx: 32'd0,  zero: 1'b0, multi: 1'b0});
    tab.push_back('{data: 16'h8000, msb: 1'b0, idx: 32'd15, zero: 1'b0, multi: 1'b0});

    // Reset state.
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; msb = 1'b0;
    d0 = '0; d1 = '0; tab_exp = none;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid w16", 32'(ov0), 32'd0);
    check("reset out_idx w16", 32'(idx0), 32'd0);
    check("reset out_zero w16", 32'(z0), 32'd0);
    check("reset out_multi w16", 32'(m0), 32'd0);
    check("reset out_valid w32", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 32'(ir0 & ir1), 32'd1);
    @(posedge clk); #1;

    // Table, sent back to back. The wide instance sees the word in its low or high half.
    for (int i = 0; i < tab.size(); i++) begin
      e0 = '{idx: tab[i].idx, zero: tab[i].zero, multi: tab[i].multi};
      send(tab[i].data, (i % 2 != 0) ? {tab[i].data, 16'h0} : {16'h0, tab[i].data},
           tab[i].msb, e0, 1'b1);
    end
    drain();

    // Latency: a single word into an empty pipe is valid exactly 2 clk after accept.
    send(16'h0420, 32'h0420_0000, 1'b1, none, 1'b0);
    @(negedge clk);
    check("latency 1 clk no out_valid", 32'(ov0 | ov1), 32'd0);
    @(negedge clk);
    check("latency 2 clk out_valid", 32'(ov0 & ov1), 32'd1);
    drain();

    // Stall: out_ready=0 with 4 words offered. Only 2 are accepted, then in_ready drops.
    out_ready = 1'b0;
    e0 = model(32'h0003, W0, 1'b0);
    e1 = model(32'h8000_0003, W1, 1'b0);
    fork
      begin
        send(16'h0003, 32'h8000_0003, 1'b0, none, 1'b0);
        send(16'h0300, 32'h0003_0000, 1'b1, none, 1'b0);
        send(16'h1000, 32'h0000_1000, 1'b0, none, 1'b0);
        send(16'h0000, 32'h0000_0000, 1'b1, none, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("stall in_ready low", 32'(ir0 | ir1), 32'd0);
        check("stall accepted count", 32'(q0.size()), 32'd2);
        check("stall out_valid", 32'(ov0 & ov1), 32'd1);
        repeat (2) @(negedge clk);
        check("stall hold idx w16", 32'(idx0), e0.idx);
        check("stall hold idx w32", 32'(idx1), e1.idx);
        check("stall hold multi", 32'(m0 & m1), 32'd1);
        check("stall hold in_ready", 32'(ir0 | ir1), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Freeze: enable=0 with the pipe full and out_ready=1. Everything holds.
    out_ready = 1'b0;
    e0 = model(32'h0050, W0, 1'b1);
    e1 = model(32'h0050_0000, W1, 1'b1);
    fork
      begin
        send(16'h0050, 32'h0050_0000, 1'b1, none, 1'b0);
        send(16'h0000, 32'h0000_0000, 1'b0, none, 1'b0);
        send(16'h2002, 32'h2000_0002, 1'b0, none, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("freeze out_valid", 32'(ov0 & ov1), 32'd1);
          check("freeze idx w16", 32'(idx0), e0.idx);
          check("freeze idx w32", 32'(idx1), e1.idx);
          check("freeze in_ready", 32'(ir0 | ir1), 32'd0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
      end
    join
    drain();

    // Random traffic with a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [31:0] r;
          r = $urandom;
          if (i % 5 == 0) r = 32'h0;
          send(r[15:0], r, r[7], none, 1'b0);
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with 2 words in flight. Neither word emerges, and the pipe restarts cleanly.
    send(16'h0010, 32'h0001_0000, 1'b0, none, 1'b0);
    send(16'h0200, 32'h0000_0200, 1'b1, none, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset flush out_valid", 32'(ov0 | ov1), 32'd0);
    @(posedge clk); #1;
    send(16'h4001, 32'h4000_0001, 1'b1, none, 1'b0);
    @(negedge clk);
    check("post-reset latency 1 clk", 32'(ov0 | ov1), 32'd0);
    @(negedge clk);
    check("post-reset latency 2 clk", 32'(ov0 & ov1), 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
